// File: rtl/mc_ctr_pkg.sv
// Shared opcode, state and control-bundle definitions for the multi-cycle
// MIPS main controller.
package mc_ctr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ADD   = 2'b00;
  localparam logic [1:0] SUB   = 2'b01;
  localparam logic [1:0] FUNCT = 2'b10;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    ERR    = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       branch_ne;
    logic       illegal_op;
    logic       bus_err;
  } ctl_t;

endpackage

// File: rtl/mc_ctr_wait.sv
// Memory wait counter: counts stalled cycles in a memory state and
// flags a timeout on the TIMEOUT-th consecutive stall.
module mc_ctr_wait #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_st,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!wait_st || mem_ready) cnt_d = '0;
  end

  // Fires on the stall that would bring the count to TIMEOUT.
  assign timeout = wait_st && !mem_ready &&
                   (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_ctr.sv
// Multi-cycle MIPS main control FSM with memory ready/timeout handshake.
// Optional MC_CTR_BNE_EN adds bne decoding and the branchNe output.
module mc_ctr
  import mc_ctr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluop,
  output logic [1:0] pcSrc,
  output logic       branchNe,
  output logic       illegalOp,
  output logic       busErr
);

`ifdef MC_CTR_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctl_t       ctl, out;
  logic       wait_st, timeout;

  assign wait_st = (state_q == FETCH) ||
                   (state_q == MEMRD) ||
                   (state_q == MEMWR);

  mc_ctr_wait #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .wait_st   (wait_st),
    .mem_ready (memReady),
    .timeout   (timeout)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctl     = '0;
    unique case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = memReady;
        ctl.pc_write  = memReady;
        if (memReady)     state_d = DECODE;
        else if (timeout) state_d = ERR;
      end
      DECODE: begin
        ctl.alu_src_b = 2'b11;
        op_d = opCode;
        case (opCode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          OP_BNE: begin
            state_d        = BNE_EN ? BRANCH : FETCH;
            ctl.illegal_op = !BNE_EN;
          end
          default: begin
            state_d        = FETCH;
            ctl.illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.ior_d    = 1'b1;
        if (memReady)     state_d = MEMWB;
        else if (timeout) state_d = ERR;
      end
      MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.ior_d     = 1'b1;
        if (memReady)     state_d = FETCH;
        else if (timeout) state_d = ERR;
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.aluop     = FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.aluop         = SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_src        = 2'b01;
        ctl.branch_ne     = BNE_EN && (op_q == OP_BNE);
        state_d = FETCH;
      end
      JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = 2'b10;
        state_d = FETCH;
      end
      ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.aluop     = ADD;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        ctl.reg_write = 1'b1;
        state_d = FETCH;
      end
      ERR: begin
        ctl.bus_err = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Reset must silence the FETCH strobes that the reset state implies.
  always_comb out = reset ? '0 : ctl;

  assign pcWrite     = out.pc_write;
  assign pcWriteCond = out.pc_write_cond;
  assign iorD        = out.ior_d;
  assign memRead     = out.mem_read;
  assign memWrite    = out.mem_write;
  assign irWrite     = out.ir_write;
  assign regDst      = out.reg_dst;
  assign memToReg    = out.mem_to_reg;
  assign regWrite    = out.reg_write;
  assign aluSrcA     = out.alu_src_a;
  assign aluSrcB     = out.alu_src_b;
  assign aluop       = out.aluop;
  assign pcSrc       = out.pc_src;
  assign branchNe    = out.branch_ne;
  assign illegalOp   = out.illegal_op;
  assign busErr      = out.bus_err;

endmodule
